// File: rtl/usr_reg_capture.sv
// USR_ACCESS consumer: synchronises the bitstream user word into aclk, captures it once
// after a stability window, decodes it as a build timestamp and serves a 4-entry read map.
module usr_reg_capture #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned STABLE_COUNT = 16
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [31:0] Usr_Reg_Data,
    input  logic        ConfigValid,
    input  logic        rd_req,
    input  logic [1:0]  rd_addr,
    output logic        rd_ack,
    output logic [31:0] rd_data,
    output logic        captured
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_CFG  = CNT_W'(STABLE_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_CAPT = 2'd2
    } state_t;

    // Vivado TIMESTAMP layout of the user word
    typedef struct packed {
        logic [4:0] day;
        logic [3:0] month;
        logic [5:0] year;
        logic [4:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
    } ts_t;

    logic [SYNC_STAGES-1:0]             vsync_q;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] dsync_q;
    logic [DATA_W-1:0]                  dprev_q;
    logic                               vsync;
    logic [DATA_W-1:0]                  dsync;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] cap_word_q, cap_word_d;
    logic              captured_q, captured_d;

    logic              rd_ack_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] rd_mux_c;
    ts_t               ts;

    assign vsync = vsync_q[SYNC_STAGES-1];
    assign dsync = dsync_q[SYNC_STAGES-1];

    // Multi-flop synchronisers for valid and data, plus one extra stage for change detect
    always_ff @(posedge aclk) begin
        if (reset) begin
            vsync_q <= '0;
            dsync_q <= '0;
            dprev_q <= '0;
        end else begin
            vsync_q[0] <= ConfigValid;
            dsync_q[0] <= Usr_Reg_Data;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                vsync_q[i] <= vsync_q[i-1];
                dsync_q[i] <= dsync_q[i-1];
            end
            dprev_q <= dsync;
        end
    end

    // Capture FSM state register
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cap_word_q <= '0;
            captured_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_word_q <= cap_word_d;
            captured_q <= captured_d;
        end
    end

    // Stability filter; the counter never passes CNT_LAST so it cannot wrap
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_word_d = cap_word_q;
        captured_d = captured_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (vsync) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!vsync) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (dsync != dprev_q) begin
                    cnt_d = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    cap_word_d = dsync;
                    captured_d = 1'b1;
                    state_d    = ST_CAPT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPT: begin
                state_d = ST_CAPT;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ts = ts_t'(cap_word_q);

    // Read map; uses the registered word, so a read on the capture edge sees the old value
    always_comb begin
        rd_mux_c = '0;
        unique case (rd_addr)
            2'd0:    rd_mux_c = cap_word_q;
            2'd1:    rd_mux_c = {17'b0, ts.year, ts.month, ts.day};
            2'd2:    rd_mux_c = {15'b0, ts.hour, ts.minute, ts.second};
            default: rd_mux_c = {16'b0, CNT_CFG, 5'b0, state_q, captured_q};
        endcase
    end

    // Single-cycle read pipeline; data holds between acknowledges
    always_ff @(posedge aclk) begin
        if (reset) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_mux_c;
            end
        end
    end

    assign rd_ack   = rd_ack_q;
    assign rd_data  = rd_data_q;
    assign captured = captured_q;

endmodule

// File: tb/tb_usr_reg_capture.sv
// Directed self-checking bench for usr_reg_capture: capture latency, stability filter,
// valid dropout, pre-capture reads, mid-operation reset and pipelined reads.
module tb_usr_reg_capture;

    logic        aclk = 1'b0;
    logic        reset;
    logic [31:0] Usr_Reg_Data;
    logic        ConfigValid;
    logic        rd_req;
    logic [1:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        captured;

    int errors = 0;
    int checks = 0;

    usr_reg_capture #(.SYNC_STAGES(2), .STABLE_COUNT(16)) dut (
        .aclk        (aclk),
        .reset       (reset),
        .Usr_Reg_Data(Usr_Reg_Data),
        .ConfigValid (ConfigValid),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .captured    (captured)
    );

    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset  = 1'b1;
        rd_req = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
    endtask

    task automatic do_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        rd_req  = 1'b1;
        rd_addr = addr;
        tick();
        rd_req = 1'b0;
        check_eq({tag, "_ack"}, 32'(rd_ack), 32'd1);
        check_eq(tag, rd_data, exp);
    endtask

    // Counts edges until captured rises (bounded) and checks the count lies in [lo,hi]
    task automatic wait_capture(input string tag, input int lo, input int hi);
        int n;
        n = 0;
        while (!captured && n < 60) begin
            tick();
            n++;
        end
        check_eq({tag, "_captured"}, 32'(captured), 32'd1);
        check_eq({tag, "_latency_in_window"}, 32'(n >= lo && n <= hi), 32'd1);
        if (n < lo || n > hi) $display("  %s latency=%0d edges", tag, n);
    endtask

    logic [31:0] ts_exp [4];

    initial begin
        ts_exp[0] = 32'h88A7502B;
        ts_exp[1] = 32'h00002631;
        ts_exp[2] = 32'h0001502B;
        ts_exp[3] = 32'h00001005;

        reset        = 1'b1;
        ConfigValid  = 1'b0;
        Usr_Reg_Data = 32'h0;
        rd_req       = 1'b0;
        rd_addr      = 2'd0;

        // Normal capture of a timestamp word
        Usr_Reg_Data = 32'h88A7502B;
        do_reset(4);
        check_eq("rst_ack", 32'(rd_ack), 32'd0);
        check_eq("rst_data", rd_data, 32'd0);
        check_eq("rst_captured", 32'(captured), 32'd0);
        ConfigValid = 1'b1;
        wait_capture("normal", 18, 20);
        for (int a = 0; a < 4; a++) do_read($sformatf("normal_rd%0d", a), 2'(a), ts_exp[a]);

        // Instability: data toggles every 5 cycles, never stable long enough
        do_reset(2);
        ConfigValid = 1'b1;
        for (int seg = 0; seg < 20; seg++) begin
            Usr_Reg_Data = (seg % 2 == 1) ? 32'h12345679 : 32'h12345678;
            repeat (5) tick();
            check_eq($sformatf("unstable_seg%0d", seg), 32'(captured), 32'd0);
        end
        do_read("unstable_status", 2'd3, 32'h00001002);
        wait_capture("unstable_hold", 1, 20);
        do_read("unstable_word", 2'd0, 32'h12345679);

        // Valid dropout restarts the window; later input changes are ignored
        Usr_Reg_Data = 32'h2468ACE1;
        ConfigValid  = 1'b0;
        do_reset(2);
        ConfigValid = 1'b1;
        repeat (10) tick();
        ConfigValid = 1'b0;
        repeat (3) tick();
        check_eq("dropout_not_yet", 32'(captured), 32'd0);
        ConfigValid = 1'b1;
        wait_capture("dropout", 18, 20);
        Usr_Reg_Data = 32'hFFFFFFFF;
        ConfigValid  = 1'b0;
        repeat (10) tick();
        check_eq("dropout_sticky", 32'(captured), 32'd1);
        do_read("dropout_word", 2'd0, 32'h2468ACE1);
        do_read("dropout_status", 2'd3, 32'h00001005);

        // Pre-capture back-to-back reads
        ConfigValid = 1'b0;
        do_reset(2);
        for (int a = 0; a < 4; a++) begin
            rd_req  = 1'b1;
            rd_addr = 2'(a);
            tick();
            check_eq($sformatf("pre_ack%0d", a), 32'(rd_ack), 32'd1);
            check_eq($sformatf("pre_rd%0d", a), rd_data, (a == 3) ? 32'h00001000 : 32'h0);
        end
        rd_req = 1'b0;
        tick();
        check_eq("pre_ack_idle", 32'(rd_ack), 32'd0);
        check_eq("pre_data_hold", rd_data, 32'h00001000);

        // Reset asserted for one edge when the counter has reached 8
        Usr_Reg_Data = 32'h88A7502B;
        ConfigValid  = 1'b0;
        do_reset(2);
        repeat (3) tick();
        ConfigValid = 1'b1;
        repeat (10) tick();
        do_read("midrst_status", 2'd3, 32'h00001002);
        check_eq("midrst_pre_captured", 32'(captured), 32'd0);
        reset   = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 2'd3;
        tick();
        reset  = 1'b0;
        rd_req = 1'b0;
        check_eq("midrst_ack", 32'(rd_ack), 32'd0);
        check_eq("midrst_data", rd_data, 32'd0);
        check_eq("midrst_captured", 32'(captured), 32'd0);
        tick();
        check_eq("midrst_no_late_ack", 32'(rd_ack), 32'd0);
        wait_capture("midrst", 17, 19);

        // Back-to-back reads after capture, address cycling 0..3
        for (int i = 0; i < 8; i++) begin
            rd_req  = 1'b1;
            rd_addr = 2'(i % 4);
            tick();
            check_eq($sformatf("b2b_ack%0d", i), 32'(rd_ack), 32'd1);
            check_eq($sformatf("b2b_rd%0d", i), rd_data, ts_exp[i % 4]);
        end
        rd_req = 1'b0;
        tick();
        check_eq("b2b_ack_end", 32'(rd_ack), 32'd0);
        check_eq("b2b_data_hold", rd_data, ts_exp[3]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
